// File: rtl/lsu_mem_master.sv
// lsu_mem_master: RV32 load/store initiator for a word-only data memory port.
// Sub-word loads are extracted and extended from whole words; sub-word stores
// become read-modify-write. Optional macro LSU_MISALIGN_EN executes misaligned
// halfword/word accesses, splitting word-crossing ones into two word accesses.
// Without it, misaligned requests return an error and never touch memory.
module lsu_mem_master #(
    parameter int WIDTH      = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_wren,
    output logic [WIDTH-1:0] mem_wr_data,
    output logic [2:0]       mem_funct3,
    input  logic [WIDTH-1:0] mem_rd_data
);

    typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

    typedef struct packed {
        logic             wr;
        logic [2:0]       funct3;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] wdata;
        logic             err;
        logic             span;
    } req_t;

    state_t             state, state_nxt;
    req_t               q;
    logic [WIDTH-1:0]   rdw0, rdw1, addr_q;
    logic [2:0]         cnt;

    logic [2:0]         in_size;
    logic               in_illegal, in_misal, in_err, in_span, in_aligned_sw;
    logic [WIDTH-1:0]   in_word0, word0, word1;

    logic [7:0]         bmask;
    logic [4:0]         sh;
    logic [2*WIDTH-1:0] rd_pair, ld_bytes, bitmask, wdata_sh, merged;
    logic [WIDTH-1:0]   ld_val;

    assign in_word0      = {req_addr[WIDTH-1:2], 2'b00};
    assign word0         = {q.addr[WIDTH-1:2], 2'b00};
    assign word1         = word0 + WIDTH'(4);
    assign in_aligned_sw = req_wr && (req_funct3 == 3'b010) && (req_addr[1:0] == 2'b00);
    assign mem_addr      = addr_q;
    assign mem_funct3    = 3'b010;

`ifdef LSU_MISALIGN_EN
    logic [3:0] in_end;
    assign in_end = {2'b00, req_addr[1:0]} + {1'b0, in_size};
`endif

    // Classify the incoming request: size, legality, misalignment, word-crossing
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   in_size = 3'd1;
            2'b01:   in_size = 3'd2;
            default: in_size = 3'd4;
        endcase
        in_illegal = req_wr ? (req_funct3[2] || req_funct3 == 3'b011)
                            : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        in_misal   = (in_size == 3'd2 && req_addr[0]) ||
                     (in_size == 3'd4 && req_addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_EN
        in_err  = in_illegal;
        in_span = !in_illegal && (in_end > 4'd4);
`else
        in_err  = in_illegal || in_misal;
        in_span = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: reads wait out the latency counter, RMW stores fall into WR0
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) begin
                if (in_err)             state_nxt = RESP;
                else if (in_aligned_sw) state_nxt = WR0;
                else                    state_nxt = RD0;
            end
            RD0:  if (cnt == 3'd0) state_nxt = q.span ? RD1 : (q.wr ? WR0 : RESP);
            RD1:  if (cnt == 3'd0) state_nxt = q.wr ? WR0 : RESP;
            WR0:  state_nxt = q.span ? WR1 : RESP;
            WR1:  state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, read-word capture, memory address and latency counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q      <= '0;
            rdw0   <= '0;
            rdw1   <= '0;
            addr_q <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    q.wr     <= req_wr;
                    q.funct3 <= req_funct3;
                    q.addr   <= req_addr;
                    q.wdata  <= req_wdata;
                    q.err    <= in_err;
                    q.span   <= in_span;
                    cnt      <= 3'(RD_LATENCY);
                    // errored requests leave the memory address untouched
                    if (!in_err) addr_q <= in_word0;
                end
                RD0: begin
                    if (cnt != 3'd0) cnt <= cnt - 3'd1;
                    else begin
                        rdw0 <= mem_rd_data;
                        if (q.span) begin
                            addr_q <= word1;
                            cnt    <= 3'(RD_LATENCY);
                        end
                    end
                end
                RD1: begin
                    if (cnt != 3'd0) cnt <= cnt - 3'd1;
                    else begin
                        rdw1 <= mem_rd_data;
                        if (q.wr) addr_q <= word0;
                    end
                end
                WR0: if (q.span) addr_q <= word1;
                default: ;
            endcase
        end
    end

    // Load extraction and store merge over the two-word window {rdw1,rdw0}
    always_comb begin
        sh       = {q.addr[1:0], 3'b000};
        rd_pair  = {rdw1, rdw0};
        ld_bytes = rd_pair >> sh;
        case (q.funct3)
            3'b000:  ld_val = {{24{ld_bytes[7]}}, ld_bytes[7:0]};
            3'b001:  ld_val = {{16{ld_bytes[15]}}, ld_bytes[15:0]};
            3'b100:  ld_val = {24'b0, ld_bytes[7:0]};
            3'b101:  ld_val = {16'b0, ld_bytes[15:0]};
            default: ld_val = ld_bytes[WIDTH-1:0];
        endcase
        case (q.funct3[1:0])
            2'b00:   bmask = 8'h01;
            2'b01:   bmask = 8'h03;
            default: bmask = 8'h0F;
        endcase
        bmask   = bmask << q.addr[1:0];
        bitmask = '0;
        for (int i = 0; i < 8; i++) bitmask[8*i +: 8] = {8{bmask[i]}};
        wdata_sh = {{WIDTH{1'b0}}, q.wdata} << sh;
        // a full aligned word mask makes the (unread) rdw words irrelevant
        merged   = (rd_pair & ~bitmask) | (wdata_sh & bitmask);
    end

    // Moore outputs decoded from the current state
    always_comb begin
        req_ready   = (state == IDLE);
        rsp_valid   = (state == RESP);
        rsp_err     = (state == RESP) && q.err;
        rsp_data    = ((state == RESP) && !q.wr && !q.err) ? ld_val : '0;
        mem_wren    = (state == WR0) || (state == WR1);
        mem_wr_data = '0;
        if (state == WR0)      mem_wr_data = merged[WIDTH-1:0];
        else if (state == WR1) mem_wr_data = merged[2*WIDTH-1:WIDTH];
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master: word memory with configurable read latency,
// directed vector table, handshake/reset sequences, and randomized requests
// checked against a byte-addressed reference memory model.
module tb_lsu_mem_master;

    localparam int RDL = 1;

    logic        clk, rst;
    logic        req_valid, req_ready, req_wr;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
    logic        mem_wren;
    logic [2:0]  mem_funct3;

    lsu_mem_master #(.WIDTH(32), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wr_data(mem_wr_data),
        .mem_funct3(mem_funct3), .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory seen by the DUT: 64 words, aliased on address bits [7:2]
    bit [31:0] dmem [64];
    bit [31:0] rd_pipe [RDL];
    bit        flash_go = 1'b0;
    assign mem_rd_data = rd_pipe[RDL-1];

    // synchronous memory: flash preload, writes, and read pipeline
    always @(posedge clk) begin
        if (flash_go) begin
            dmem[0] <= 32'h0000_3039;
            dmem[2] <= 32'h0001_8A92;
            dmem[3] <= 32'hDEAD_BEEF;
            dmem[4] <= 32'h1122_3344;
        end else if (mem_wren) begin
            dmem[mem_addr[7:2]] <= mem_wr_data;
        end
        rd_pipe[0] <= dmem[mem_addr[7:2]];
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // write-strobe monitor
    int        wren_total = 0;
    bit [31:0] last_wd = 0;
    always @(negedge clk) begin
        if (mem_wren) begin
            wren_total <= wren_total + 1;
            last_wd    <= mem_wr_data;
        end
    end

    // reference: flat byte memory, 256 bytes, same aliasing as dmem
    bit [7:0] ref_mem [256];

    function automatic bit [31:0] ref_word(input bit [31:0] a);
        bit [31:0] v, b;
        v = 0;
        for (int i = 0; i < 4; i++) begin
            b = a + i;
            v[8*i +: 8] = ref_mem[b[7:0]];
        end
        return v;
    endfunction

    task automatic ref_set_word(input bit [31:0] a, input bit [31:0] v);
        bit [31:0] b;
        for (int i = 0; i < 4; i++) begin
            b = a + i;
            ref_mem[b[7:0]] = v[8*i +: 8];
        end
    endtask

    // Architectural view of a request: bytes in, bytes out, word accesses counted
    task automatic model_req(input bit wr, input bit [2:0] f3, input bit [31:0] addr,
                             input bit [31:0] wd, output bit [31:0] data, output bit err,
                             output int nrd, output int nwr);
        int size, nwords;
        bit illegal, misal;
        bit [31:0] v, b;
        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        illegal = wr ? (f3[2] || f3 == 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        misal   = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'd0);
        data = 0; err = 0; nrd = 0; nwr = 0;
`ifdef LSU_MISALIGN_EN
        if (illegal) begin err = 1; return; end
`else
        if (illegal || misal) begin err = 1; return; end
`endif
        nwords = (int'(addr[1:0]) + size > 4) ? 2 : 1;
        if (!wr) begin
            v = 0;
            for (int i = 0; i < size; i++) begin
                b = addr + i;
                v[8*i +: 8] = ref_mem[b[7:0]];
            end
            if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
            data = v;
            nrd  = nwords;
        end else begin
            for (int i = 0; i < size; i++) begin
                b = addr + i;
                ref_mem[b[7:0]] = wd[8*i +: 8];
            end
            nwr = nwords;
            nrd = (size == 4 && addr[1:0] == 2'd0) ? 0 : nwords;
        end
    endtask

    task automatic chk(input string name, input bit [31:0] got, input bit [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Issue one request and check data, error, latency, write count and data
    task automatic run_one(input string name, input bit wr, input bit [2:0] f3,
                           input bit [31:0] addr, input bit [31:0] wd, input bit use_tbl,
                           input bit [31:0] t_data, input bit t_err);
        bit [31:0] m_data, e_data, got_data, addr_before, wa;
        bit        m_err, e_err, got_err;
        int        nrd, nwr, lat, w0;
        model_req(wr, f3, addr, wd, m_data, m_err, nrd, nwr);
        e_data = use_tbl ? t_data : m_data;
        e_err  = use_tbl ? t_err  : m_err;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
        addr_before = mem_addr;
        w0 = wren_total;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = k; break; end
        end
        got_data = rsp_data;
        got_err  = rsp_err;
        chk({name, "/lat"}, 32'(lat), 32'(1 + nrd * (RDL + 1) + nwr));
        chk({name, "/data"}, got_data, e_data);
        chk({name, "/err"}, {31'b0, got_err}, {31'b0, e_err});
        chk({name, "/nwr"}, 32'(wren_total - w0), 32'(nwr));
        if (nwr > 0) begin
            wa = {addr[31:2], 2'b00} + ((nwr == 2) ? 32'd4 : 32'd0);
            chk({name, "/wdata"}, last_wd, ref_word(wa));
        end
        if (e_err) chk({name, "/addr_hold"}, mem_addr, addr_before);
        @(negedge clk);
        chk({name, "/pulse"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    typedef struct {
        string     name;
        bit        wr;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wd;
        bit [31:0] exp_data;
        bit        exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0] got, rwd, raddr;
        bit        rwr;
        bit [2:0]  rf3;
        int        bad;

        rst = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        #12;
        chk("rst/ready", {31'b0, req_ready}, 32'd1);
        chk("rst/rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst/rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst/rsp_data", rsp_data, 32'd0);
        chk("rst/mem_wren", {31'b0, mem_wren}, 32'd0);
        chk("rst/mem_addr", mem_addr, 32'd0);
        chk("rst/mem_wr_data", mem_wr_data, 32'd0);
        chk("mem_funct3", {29'b0, mem_funct3}, 32'd2);
        @(negedge clk) rst = 1'b1;

        // flash preload, mirrored in the reference
        @(negedge clk) flash_go = 1'b1;
        @(posedge clk);
        #1 flash_go = 1'b0;
        ref_set_word(32'd0,  32'h0000_3039);
        ref_set_word(32'd8,  32'h0001_8A92);
        ref_set_word(32'd12, 32'hDEAD_BEEF);
        ref_set_word(32'd16, 32'h1122_3344);

        vecs.push_back('{"lw12",   1'b0, 3'b010, 32'd12, 32'd0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{"lb13",   1'b0, 3'b000, 32'd13, 32'd0,         32'hFFFF_FFBE, 1'b0});
        vecs.push_back('{"lbu13",  1'b0, 3'b100, 32'd13, 32'd0,         32'h0000_00BE, 1'b0});
        vecs.push_back('{"lhu14",  1'b0, 3'b101, 32'd14, 32'd0,         32'h0000_DEAD, 1'b0});
        vecs.push_back('{"lh14",   1'b0, 3'b001, 32'd14, 32'd0,         32'hFFFF_DEAD, 1'b0});
        vecs.push_back('{"sb8",    1'b1, 3'b000, 32'd8,  32'h0000_00A5, 32'd0,         1'b0});
        vecs.push_back('{"lw8",    1'b0, 3'b010, 32'd8,  32'd0,         32'h0001_8AA5, 1'b0});
`ifdef LSU_MISALIGN_EN
        vecs.push_back('{"lw14",   1'b0, 3'b010, 32'd14, 32'd0,         32'h3344_DEAD, 1'b0});
        vecs.push_back('{"lh13",   1'b0, 3'b001, 32'd13, 32'd0,         32'hFFFF_ADBE, 1'b0});
`else
        vecs.push_back('{"lw14",   1'b0, 3'b010, 32'd14, 32'd0,         32'd0,         1'b1});
        vecs.push_back('{"lh13",   1'b0, 3'b001, 32'd13, 32'd0,         32'd0,         1'b1});
`endif
        vecs.push_back('{"ld011",  1'b0, 3'b011, 32'd0,  32'd0,         32'd0,         1'b1});
        vecs.push_back('{"st100",  1'b1, 3'b100, 32'd0,  32'h1,         32'd0,         1'b1});
        vecs.push_back('{"sw4",    1'b1, 3'b010, 32'd4,  32'hCAFE_F00D, 32'd0,         1'b0});
        vecs.push_back('{"lw4",    1'b0, 3'b010, 32'd4,  32'd0,         32'hCAFE_F00D, 1'b0});
        vecs.push_back('{"sh22",   1'b1, 3'b001, 32'd22, 32'hFFFF_1234, 32'd0,         1'b0});
        vecs.push_back('{"lw20",   1'b0, 3'b010, 32'd20, 32'd0,         32'h1234_0000, 1'b0});
        vecs.push_back('{"lb23",   1'b0, 3'b000, 32'd23, 32'd0,         32'h0000_0012, 1'b0});

        foreach (vecs[i])
            run_one(vecs[i].name, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd,
                    1'b1, vecs[i].exp_data, vecs[i].exp_err);

        // req_valid held through a busy load; new fields must not disturb it
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_funct3 = 3'b010; req_addr = 32'd12;
        @(posedge clk);
        #1 req_addr = 32'd0;
        bad = 0;
        got = 32'hFFFF_FFFF;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) begin got = rsp_data; break; end
            if (req_ready) bad++;
        end
        chk("hold/busy_ready", 32'(bad), 32'd0);
        chk("hold/first_data", got, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("hold/ready_after", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 32'hFFFF_FFFF;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) begin got = rsp_data; break; end
        end
        chk("hold/second_data", got, 32'h0000_3039);

        // reset while a load sits in RD0
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_funct3 = 3'b010; req_addr = 32'd12;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("abort/rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("abort/mem_wren", {31'b0, mem_wren}, 32'd0);
        chk("abort/mem_addr", mem_addr, 32'd0);
        chk("abort/ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk) rst = 1'b1;
        run_one("abort/lw0", 1'b0, 3'b010, 32'd0, 32'd0, 1'b1, 32'h0000_3039, 1'b0);

        // randomized requests against the reference model
        for (int i = 0; i < 80; i++) begin
            rwr   = 1'($urandom_range(0, 1));
            rf3   = 3'($urandom_range(0, 7));
            raddr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                : 32'($urandom_range(0, 255));
            rwd   = $urandom;
            run_one("rnd", rwr, rf3, raddr, rwd, 1'b0, 32'd0, 1'b0);
        end

        bad = 0;
        for (int w = 0; w < 64; w++)
            if (dmem[w] !== ref_word(32'(w * 4))) bad++;
        chk("mem_image", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
